// File: rtl/mem_exc_ctrl.sv
// rtl/mem_exc_ctrl.sv - MEM stage register with exception resolution and interrupt sync
//
// Purpose:
//   Holds the MEM pipeline stage, resolves the exception reported to CP0 for
//   the instruction currently in MEM (interrupt, upstream code, data address
//   error), gates data-memory strobes for excepting instructions, and
//   synchronises the external interrupt lines.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n         clock (rising edge), async active-low reset
//   ex_valid, ex_pc, ex_in_delay   EXE-stage instruction info
//   ex_exccode                     exception already detected upstream
//   ex_mem_re, ex_mem_we           load / store request
//   ex_mem_size, ex_mem_addr       access size (0 byte, 1 half, 2/3 word), address
//   stall_i, flush_i               hold / bubble the MEM stage register
//   status_i, cause_i              CP0 Status / Cause
//   hw_int_i, timer_int_i          raw external interrupts, CP0 timer interrupt
//   int_o                          synchronised interrupt vector to CP0
//   exccode_o, pc_o, in_delay_o    resolved exception info to CP0
//   badvaddr_o                     faulting address to CP0
//   mem_re_o, mem_we_o             gated data-memory strobes
//   valid_o                        MEM stage holds a valid instruction

module mem_exc_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_in_delay,
  input  logic [4:0]  ex_exccode,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic [1:0]  ex_mem_size,
  input  logic [31:0] ex_mem_addr,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [5:0]  hw_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [31:0] badvaddr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic        valid_o
);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_NONE = 5'h10;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  // MEM stage register
  logic        valid_q,    valid_d;
  logic [31:0] pc_q,       pc_d;
  logic        in_delay_q, in_delay_d;
  logic [4:0]  exccode_q,  exccode_d;
  logic        re_q,       re_d;
  logic        we_q,       we_d;
  logic [1:0]  size_q,     size_d;
  logic [31:0] addr_q,     addr_d;

  // Two-flop interrupt synchroniser
  logic [5:0]  sync1_q;
  logic [5:0]  sync2_q;

  logic        misalign;
  logic        int_req;
  logic [4:0]  exc_res;
  logic [31:0] badv_res;

  // Flush beats stall; a flushed slot is a clean bubble.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    in_delay_d = in_delay_q;
    exccode_d  = exccode_q;
    re_d       = re_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      pc_d       = 32'h0;
      in_delay_d = 1'b0;
      exccode_d  = EXC_NONE;
      re_d       = 1'b0;
      we_d       = 1'b0;
      size_d     = 2'd0;
      addr_d     = 32'h0;
    end else if (!stall_i) begin
      valid_d    = ex_valid;
      pc_d       = ex_pc;
      in_delay_d = ex_in_delay;
      exccode_d  = ex_exccode;
      re_d       = ex_mem_re;
      we_d       = ex_mem_we;
      size_d     = ex_mem_size;
      addr_d     = ex_mem_addr;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= 32'h0;
      in_delay_q <= 1'b0;
      exccode_q  <= EXC_NONE;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'h0;
      sync1_q    <= 6'h0;
      sync2_q    <= 6'h0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      in_delay_q <= in_delay_d;
      exccode_q  <= exccode_d;
      re_q       <= re_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      sync1_q    <= hw_int_i;
      sync2_q    <= sync1_q;
    end
  end

  // The timer interrupt is already synchronous and shares line 5.
  assign int_o = {sync2_q[5] | timer_int_i, sync2_q[4:0]};

  // Reserved size 3 is treated as a word access.
  always_comb begin
    misalign = 1'b0;
    if (size_q == SIZE_BYTE) begin
      misalign = 1'b0;
    end else if (size_q == SIZE_HALF) begin
      misalign = addr_q[0];
    end else begin
      misalign = |addr_q[1:0];
    end
  end

  // IE set, EXL clear, and some pending line unmasked.
  assign int_req = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));

  // Interrupt outranks everything, including ERET; a bubble reports nothing
  // so a pending interrupt waits for the next valid instruction.
  always_comb begin
    exc_res  = EXC_NONE;
    badv_res = 32'h0;
    if (valid_q) begin
      if (int_req) begin
        exc_res = EXC_INT;
      end else if (exccode_q != EXC_NONE) begin
        exc_res = exccode_q;
        if (exccode_q == EXC_ADEL) begin
          badv_res = pc_q;
        end
      end else if (misalign && re_q) begin
        exc_res  = EXC_ADEL;
        badv_res = addr_q;
      end else if (misalign && we_q) begin
        exc_res  = EXC_ADES;
        badv_res = addr_q;
      end
    end
  end

  assign exccode_o  = exc_res;
  assign badvaddr_o = badv_res;
  assign pc_o       = valid_q ? pc_q : 32'h0;
  assign in_delay_o = valid_q & in_delay_q;
  assign valid_o    = valid_q;

  // An excepting instruction must not touch memory.
  assign mem_re_o = re_q & valid_q & (exc_res == EXC_NONE);
  assign mem_we_o = we_q & valid_q & (exc_res == EXC_NONE);

  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule

// File: tb/tb_mem_exc_ctrl.sv
// tb/tb_mem_exc_ctrl.sv - self-checking bench for mem_exc_ctrl

module tb_mem_exc_ctrl;

  localparam logic [4:0] X_INT  = 5'h00;
  localparam logic [4:0] X_ADEL = 5'h04;
  localparam logic [4:0] X_ADES = 5'h05;
  localparam logic [4:0] X_OV   = 5'h0c;
  localparam logic [4:0] X_NONE = 5'h10;
  localparam logic [4:0] X_ERET = 5'h11;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_in_delay;
  logic [4:0]  ex_exccode;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_mem_addr;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [5:0]  hw_int_i;
  logic        timer_int_i;
  logic [5:0]  int_o;
  logic [4:0]  exccode_o;
  logic [31:0] pc_o;
  logic        in_delay_o;
  logic [31:0] badvaddr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic        valid_o;

  int total = 0;
  int bad   = 0;

  mem_exc_ctrl dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_in_delay (ex_in_delay),
    .ex_exccode  (ex_exccode),
    .ex_mem_re   (ex_mem_re),
    .ex_mem_we   (ex_mem_we),
    .ex_mem_size (ex_mem_size),
    .ex_mem_addr (ex_mem_addr),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .status_i    (status_i),
    .cause_i     (cause_i),
    .hw_int_i    (hw_int_i),
    .timer_int_i (timer_int_i),
    .int_o       (int_o),
    .exccode_o   (exccode_o),
    .pc_o        (pc_o),
    .in_delay_o  (in_delay_o),
    .badvaddr_o  (badvaddr_o),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .valid_o     (valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the instruction sitting in MEM, plus a log of hw_int_i seen at
  // every edge since reset (the interrupt vector lags that log by two edges).
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_dly;
  logic [4:0]  m_exc;
  logic        m_re;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  int          edge_cnt;
  logic [5:0]  hw_log [0:255];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 0;
      m_valid  <= 1'b0;
      m_exc    <= X_NONE;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_pc     <= 32'h0;
      m_dly    <= 1'b0;
      m_size   <= 2'd0;
      m_addr   <= 32'h0;
    end else begin
      hw_log[edge_cnt % 256] <= hw_int_i;
      edge_cnt <= edge_cnt + 1;
      if (flush_i) begin
        m_valid <= 1'b0;
        m_exc   <= X_NONE;
        m_re    <= 1'b0;
        m_we    <= 1'b0;
      end else if (!stall_i) begin
        m_valid <= ex_valid;
        m_pc    <= ex_pc;
        m_dly   <= ex_in_delay;
        m_exc   <= ex_exccode;
        m_re    <= ex_mem_re;
        m_we    <= ex_mem_we;
        m_size  <= ex_mem_size;
        m_addr  <= ex_mem_addr;
      end
    end
  end

  function automatic bit bad_align(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [5:0]  e_int;
    logic [4:0]  e_exc;
    logic [31:0] e_badv;
    bit          ireq;
    e_int = (edge_cnt >= 2) ? hw_log[(edge_cnt - 2) % 256] : 6'h0;
    e_int[5] = e_int[5] | timer_int_i;
    ireq = status_i[0] && !status_i[1] && ((status_i[15:8] & cause_i[15:8]) != 0);
    e_exc  = X_NONE;
    e_badv = 32'h0;
    if (m_valid) begin
      if (ireq) e_exc = X_INT;
      else if (m_exc != X_NONE) begin
        e_exc = m_exc;
        if (m_exc == X_ADEL) e_badv = m_pc;
      end else if (bad_align(m_size, m_addr) && m_re) begin
        e_exc = X_ADEL; e_badv = m_addr;
      end else if (bad_align(m_size, m_addr) && m_we) begin
        e_exc = X_ADES; e_badv = m_addr;
      end
    end
    cmp("m_int",   {26'h0, int_o},     {26'h0, e_int});
    cmp("m_exc",   {27'h0, exccode_o}, {27'h0, e_exc});
    cmp("m_pc",    pc_o,               m_valid ? m_pc : 32'h0);
    cmp("m_dly",   {31'h0, in_delay_o}, {31'h0, m_valid & m_dly});
    cmp("m_badv",  badvaddr_o,         e_badv);
    cmp("m_re",    {31'h0, mem_re_o},  {31'h0, m_re & m_valid & (e_exc == X_NONE)});
    cmp("m_we",    {31'h0, mem_we_o},  {31'h0, m_we & m_valid & (e_exc == X_NONE)});
    cmp("m_valid", {31'h0, valid_o},   {31'h0, m_valid});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic v, input logic [31:0] pc, input logic dly,
                       input logic [4:0] exc, input logic re, input logic we,
                       input logic [1:0] sz, input logic [31:0] addr);
    ex_valid    = v;
    ex_pc       = pc;
    ex_in_delay = dly;
    ex_exccode  = exc;
    ex_mem_re   = re;
    ex_mem_we   = we;
    ex_mem_size = sz;
    ex_mem_addr = addr;
    cyc();
  endtask

  task automatic check_all_idle(input string tag);
    cmp({tag, "_int"},   {26'h0, int_o},     32'h0);
    cmp({tag, "_exc"},   {27'h0, exccode_o}, 32'h10);
    cmp({tag, "_pc"},    pc_o,               32'h0);
    cmp({tag, "_dly"},   {31'h0, in_delay_o}, 32'h0);
    cmp({tag, "_badv"},  badvaddr_o,         32'h0);
    cmp({tag, "_re"},    {31'h0, mem_re_o},  32'h0);
    cmp({tag, "_we"},    {31'h0, mem_we_o},  32'h0);
    cmp({tag, "_valid"}, {31'h0, valid_o},   32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_pc = 0; ex_in_delay = 0; ex_exccode = X_NONE;
    ex_mem_re = 0; ex_mem_we = 0; ex_mem_size = 0; ex_mem_addr = 0;
    stall_i = 0; flush_i = 0; status_i = 0; cause_i = 0;
    hw_int_i = 0; timer_int_i = 0;
    #1;
    check_all_idle("rst");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    cmp("post_rst_valid", {31'h0, valid_o}, 32'h0);

    // Misaligned load
    issue(1, 32'h8000_0100, 0, X_NONE, 1, 0, 2'd2, 32'h0000_0002);
    cmp("lw_exc",  {27'h0, exccode_o}, 32'h04);
    cmp("lw_badv", badvaddr_o, 32'h0000_0002);
    cmp("lw_re",   {31'h0, mem_re_o}, 32'h0);

    // Misaligned halfword store, then byte store to the same address
    issue(1, 32'h8000_0104, 0, X_NONE, 0, 1, 2'd1, 32'h0000_0003);
    cmp("sh_exc",  {27'h0, exccode_o}, 32'h05);
    cmp("sh_badv", badvaddr_o, 32'h3);
    issue(1, 32'h8000_0108, 0, X_NONE, 0, 1, 2'd0, 32'h0000_0003);
    cmp("sb_exc",  {27'h0, exccode_o}, 32'h10);
    cmp("sb_we",   {31'h0, mem_we_o}, 32'h1);

    // Reserved size behaves as word
    issue(1, 32'h8000_010c, 0, X_NONE, 1, 0, 2'd3, 32'h0000_0001);
    cmp("rsv_exc", {27'h0, exccode_o}, 32'h04);

    // Interrupt synchroniser latency
    ex_valid = 0;
    status_i = 32'h1000_0401;
    hw_int_i = 6'h01;
    cyc();
    hw_int_i = 6'h00;
    cmp("sync_1edge", {26'h0, int_o}, 32'h0);
    cyc();
    cmp("sync_2edge", {26'h0, int_o}, 32'h01);
    cyc();
    cmp("sync_gone",  {26'h0, int_o}, 32'h0);

    cause_i = 32'h0000_0400;
    issue(1, 32'h8000_0200, 1, X_NONE, 0, 0, 2'd2, 32'h0);
    cmp("int_exc", {27'h0, exccode_o}, 32'h00);
    cmp("int_pc",  pc_o, 32'h8000_0200);
    cmp("int_dly", {31'h0, in_delay_o}, 32'h1);

    // Pending interrupt during bubbles
    ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmp("bub_exc", {27'h0, exccode_o}, 32'h10);
    end
    issue(1, 32'h8000_0300, 0, X_NONE, 0, 0, 2'd2, 32'h0);
    cmp("bub_then_int", {27'h0, exccode_o}, 32'h00);
    status_i = 32'h1000_0403;
    #1;
    cmp("exl_masks", {27'h0, exccode_o}, 32'h10);

    // ERET loses to an interrupt
    status_i = 32'h1000_0401;
    issue(1, 32'h8000_0304, 0, X_ERET, 0, 0, 2'd2, 32'h0);
    cmp("eret_int", {27'h0, exccode_o}, 32'h00);
    status_i = 32'h0;
    #1;
    cmp("eret_plain", {27'h0, exccode_o}, 32'h11);
    cause_i = 32'h0;

    // Stall + flush, then stall alone
    issue(1, 32'h8000_0400, 0, X_NONE, 1, 0, 2'd2, 32'h0000_0004);
    cmp("lw_ok_re", {31'h0, mem_re_o}, 32'h1);
    stall_i = 1; flush_i = 1;
    cyc();
    cmp("sf_valid", {31'h0, valid_o}, 32'h0);
    cmp("sf_re",    {31'h0, mem_re_o}, 32'h0);
    stall_i = 0; flush_i = 0;
    issue(1, 32'h8000_0500, 0, X_NONE, 1, 0, 2'd2, 32'h0000_0008);
    stall_i = 1;
    ex_pc = 32'h8000_0600; ex_mem_re = 0; ex_mem_we = 1; ex_mem_addr = 32'h1;
    cyc(); cyc();
    cmp("hold_pc",  pc_o, 32'h8000_0500);
    cmp("hold_re",  {31'h0, mem_re_o}, 32'h1);
    cmp("hold_we",  {31'h0, mem_we_o}, 32'h0);
    cmp("hold_exc", {27'h0, exccode_o}, 32'h10);
    stall_i = 0;

    // Upstream code beats misalignment; fetch ADEL reports pc
    issue(1, 32'h8000_0700, 0, X_OV, 0, 1, 2'd2, 32'h0000_0002);
    cmp("ov_exc",  {27'h0, exccode_o}, 32'h0c);
    cmp("ov_badv", badvaddr_o, 32'h0);
    cmp("ov_we",   {31'h0, mem_we_o}, 32'h0);
    issue(1, 32'h8000_0701, 0, X_ADEL, 0, 0, 2'd2, 32'h0);
    cmp("if_exc",  {27'h0, exccode_o}, 32'h04);
    cmp("if_badv", badvaddr_o, 32'h8000_0701);

    timer_int_i = 1;
    #1;
    cmp("timer_int", {26'h0, int_o}, 32'h20);
    timer_int_i = 0;

    // Asynchronous reset mid-stream
    hw_int_i = 6'h03;
    issue(1, 32'h8000_0800, 0, X_NONE, 1, 0, 2'd2, 32'h0000_0010);
    cyc();
    cmp("pre_rst_valid", {31'h0, valid_o}, 32'h1);
    cmp("pre_rst_int",   {26'h0, int_o}, 32'h03);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_idle("arst");
    hw_int_i = 6'h0;
    cyc();
    rst_n = 1'b1;
    #1;
    cmp("rel_valid", {31'h0, valid_o}, 32'h0);
    cyc();
    cmp("resume_valid", {31'h0, valid_o}, 32'h1);
    cmp("resume_pc",    pc_o, 32'h8000_0800);
    cmp("resume_re",    {31'h0, mem_re_o}, 32'h1);

    ex_valid = 0;
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
